reg_file_mp: RTL and testbench

//  Parametrised multi-read-port register file for the RISC-V multicycle datapath; successor to the single-port file.
//  NRD registered read ports, one write-back port with ALU/memory source select, optional hardwired x0,

---
 rtl/reg_file_mp_pkg.sv | 21 ++
 rtl/rf_read_port.sv | 42 ++++
 rtl/reg_file_mp.sv | 103 ++++++++++
 tb/tb_reg_file_mp.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multicycle RISC-V register file: default sizes,
// clear-FSM state encoding and the control-unit phase codes that drive rd_en/wr_en.
package reg_file_mp_pkg;

    localparam int RV_XLEN = 64;
    localparam int RV_NREG = 32;

    typedef enum logic {
        RF_CLEAR,
        RF_READY
    } rf_state_e;

    // The control unit raises rd_en in PH_READ and wr_en in PH_WB.
    typedef enum logic [1:0] {
        PH_FETCH,
        PH_DECODE,
        PH_READ,
        PH_WB
    } rv_phase_e;

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: hardwired-zero check, write-to-read bypass and
// an output register that holds its value whenever capture is low.
module rf_read_port
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN     = RV_XLEN,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic [AW-1:0]   raddr,
    input  logic            wr_en,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] reg_val,
    output logic [XLEN-1:0] rdata
);

    logic is_zero;
    logic is_bypass;

    assign is_zero   = (ZERO_REG != 0) && (raddr == '0);
    assign is_bypass = wr_en && (raddr == waddr);

    // Zero check wins over bypass so a discarded write to x0 never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (capture) begin
            if (is_zero) begin
                rdata <= '0;
            end else if (is_bypass) begin
                rdata <= wdata;
            end else begin
                rdata <= reg_val;
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a post-reset clear sweep; ready rises
// once every register has been zeroed, after which reads and writes are honoured.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN     = RV_XLEN,
    parameter int NREG     = RV_NREG,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    input  logic                wr_en,
    input  logic                mem_to_reg,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     in_alu,
    input  logic [XLEN-1:0]     in_mem,
    output logic                ready,
    output logic [XLEN-1:0]     wb_data
);

    // ptr carries one extra bit so the compare against NREG-1 never sees a wrap.
    localparam logic [AW:0] PTR_LAST = (AW+1)'(NREG - 1);

    rf_state_e       state;
    logic [AW:0]     ptr;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] wdata;
    logic            active;
    logic            wr_zero;
    logic            wr_commit;

    assign active    = (state == RF_READY);
    assign wdata     = mem_to_reg ? in_mem : in_alu;
    assign wr_zero   = (ZERO_REG != 0) && (waddr == '0);
    assign wr_commit = active && wr_en && !wr_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RF_CLEAR;
            ptr     <= '0;
            ready   <= 1'b0;
            wb_data <= '0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state <= RF_READY;
                        ready <= 1'b1;
                    end
                end
                RF_READY: begin
                    if (wr_commit) begin
                        wb_data <= wdata;
                    end
                end
                default: begin
                    state <= RF_CLEAR;
                    ptr   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == RF_CLEAR) begin
                regs[ptr[AW-1:0]] <= '0;
            end else if (wr_commit) begin
                regs[waddr] <= wdata;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[k*AW +: AW];

        rf_read_port #(
            .XLEN    (XLEN),
            .AW      (AW),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .clk    (clk),
            .rst    (rst),
            .capture(active && rd_en),
            .raddr  (ra),
            .wr_en  (wr_en),
            .waddr  (waddr),
            .wdata  (wdata),
            .reg_val(regs[ra]),
            .rdata  (rdata[k*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: directed scenarios plus random traffic, every cycle's
// expected outputs queued by a reference model and compared by a monitor.
module tb_reg_file_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int ZR   = 1;
    localparam int AW   = $clog2(NREG);
    localparam int EW   = 1 + XLEN + NRD*XLEN;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rd_en = 1'b0;
    logic [NRD*AW-1:0]   raddr = '0;
    logic [NRD*XLEN-1:0] rdata;
    logic                wr_en = 1'b0;
    logic                mem_to_reg = 1'b0;
    logic [AW-1:0]       waddr = '0;
    logic [XLEN-1:0]     in_alu = '0;
    logic [XLEN-1:0]     in_mem = '0;
    logic                ready;
    logic [XLEN-1:0]     wb_data;

    reg_file_mp #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .NRD     (NRD),
        .ZERO_REG(ZR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .raddr     (raddr),
        .rdata     (rdata),
        .wr_en     (wr_en),
        .mem_to_reg(mem_to_reg),
        .waddr     (waddr),
        .in_alu    (in_alu),
        .in_mem    (in_mem),
        .ready     (ready),
        .wb_data   (wb_data)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // The model tracks architectural contents only; registers read as zero from
    // reset onward and the file simply becomes usable NREG cycles later.
    logic [XLEN-1:0]     m_regs [NREG];
    logic [NRD*XLEN-1:0] m_rdata;
    logic [XLEN-1:0]     m_wb;
    logic                m_ready;
    int                  m_left;

    logic [EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step_model();
        logic [XLEN-1:0] wd;
        logic [AW-1:0]   a;
        if (rst) begin
            for (int i = 0; i < NREG; i++) m_regs[i] = '0;
            m_rdata = '0;
            m_wb    = '0;
            m_ready = 1'b0;
            m_left  = NREG;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else begin
            wd = mem_to_reg ? in_mem : in_alu;
            if (rd_en) begin
                for (int k = 0; k < NRD; k++) begin
                    a = raddr[k*AW +: AW];
                    if (ZR != 0 && a == 0)           m_rdata[k*XLEN +: XLEN] = '0;
                    else if (wr_en && a == waddr)    m_rdata[k*XLEN +: XLEN] = wd;
                    else                             m_rdata[k*XLEN +: XLEN] = m_regs[a];
                end
            end
            if (wr_en && !(ZR != 0 && waddr == 0)) begin
                m_regs[waddr] = wd;
                m_wb          = wd;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        step_model();
        exp_q.push_back({m_ready, m_wb, m_rdata});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_ra(input int k, input logic [AW-1:0] a);
        raddr[k*AW +: AW] = a;
    endtask

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [XLEN-1:0] d, input logic from_mem);
        wr_en      = 1'b1;
        waddr      = a;
        mem_to_reg = from_mem;
        if (from_mem) in_mem = d; else in_alu = d;
    endtask

    task automatic dump_check(input string name);
        for (int i = 0; i < NREG; i++) check(name, dut.regs[i], m_regs[i]);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] item;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                item = exp_q.pop_front();
                check("sb_ready", ready, item[EW-1]);
                check("sb_wb_data", wb_data, item[EW-2 -: XLEN]);
                check("sb_rdata", rdata, item[NRD*XLEN-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(negedge clk);

        // 1: one reset cycle, then ready must rise on the NREG-th edge.
        rst = 1'b1;
        cycle();
        check("t1_reset_ready", ready, 1'b0);
        check("t1_reset_rdata", rdata, '0);
        idle();
        for (int i = 1; i <= NREG; i++) begin
            cycle();
            check("t1_ready_edge", ready, (i == NREG));
        end
        rd_en = 1'b1;
        for (int r = 0; r < NREG; r += 2) begin
            set_ra(0, AW'(r));
            set_ra(1, AW'(r + 1));
            cycle();
            check("t1_clear_read", rdata, '0);
        end
        idle();

        // 2: write then read back next cycle; also seed x6 for test 3.
        write(5'd5, 64'hDEAD_BEEF, 1'b0);
        cycle();
        write(5'd6, 64'h6666, 1'b0);
        rd_en = 1'b1;
        set_ra(0, 5'd5);
        set_ra(1, 5'd1);
        cycle();
        check("t2_rdata0", rdata[XLEN-1:0], 64'hDEAD_BEEF);
        idle();

        // 3: same-cycle write/read bypass from the memory source.
        write(5'd7, 64'h1234, 1'b1);
        rd_en = 1'b1;
        set_ra(0, 5'd7);
        set_ra(1, 5'd6);
        cycle();
        check("t3_bypass_rdata0", rdata[XLEN-1:0], 64'h1234);
        check("t3_old_rdata1", rdata[2*XLEN-1:XLEN], 64'h6666);
        idle();

        // 4: write to x0 is discarded and wb_data keeps the last committed value.
        write(5'd0, 64'hFFFF, 1'b0);
        rd_en = 1'b1;
        set_ra(0, 5'd0);
        set_ra(1, 5'd0);
        cycle();
        idle();
        rd_en = 1'b1;
        cycle();
        check("t4_x0_port0", rdata[XLEN-1:0], (ZR != 0) ? 64'h0 : 64'hFFFF);
        check("t4_x0_port1", rdata[2*XLEN-1:XLEN], (ZR != 0) ? 64'h0 : 64'hFFFF);
        check("t4_wb_kept", wb_data, (ZR != 0) ? 64'h1234 : 64'hFFFF);
        idle();

        // 5: reset mid-write, then again mid-sweep while writes are attempted.
        for (int i = 1; i <= 10; i++) begin
            write(AW'(i), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            cycle();
        end
        write(5'd11, 64'hABCD, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            write(AW'($urandom_range(1, NREG-1)), {$urandom, $urandom}, 1'b0);
            rd_en = 1'b1;
            cycle();
        end
        check("t5_ready_low_mid_sweep", ready, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            write(AW'($urandom_range(1, NREG-1)), {$urandom, $urandom}, 1'b0);
            cycle();
        end
        idle();
        check("t5_ready_after_sweep", ready, 1'b1);
        dump_check("t5_regs_cleared");
        rd_en = 1'b1;
        for (int r = 0; r < NREG; r += 2) begin
            set_ra(0, AW'(r));
            set_ra(1, AW'(r + 1));
            cycle();
            check("t5_clear_read", rdata, '0);
        end
        idle();

        // 6a: rd_en low for 5 cycles while addresses and writes change.
        write(5'd3, 64'h3333, 1'b0);
        rd_en = 1'b1;
        set_ra(0, 5'd3);
        set_ra(1, 5'd3);
        cycle();
        idle();
        for (int i = 0; i < 5; i++) begin
            set_ra(0, AW'($urandom_range(0, NREG-1)));
            set_ra(1, AW'($urandom_range(0, NREG-1)));
            write(AW'($urandom_range(1, NREG-1)), {$urandom, $urandom}, 1'b0);
            cycle();
            check("t6_hold", rdata, {64'h3333, 64'h3333});
        end
        idle();

        // 6b: random traffic with a narrow address range to provoke bypass hits.
        for (int i = 0; i < 500; i++) begin
            rst        = ($urandom_range(0, 249) == 0);
            rd_en      = 1'($urandom_range(0, 1));
            wr_en      = 1'($urandom_range(0, 1));
            mem_to_reg = 1'($urandom_range(0, 1));
            waddr      = AW'($urandom_range(0, 7));
            in_alu     = {$urandom, $urandom};
            in_mem     = {$urandom, $urandom};
            for (int k = 0; k < NRD; k++) begin
                set_ra(k, ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7))
                                                      : AW'($urandom_range(0, NREG-1)));
            end
            cycle();
        end
        idle();
        for (int i = 0; i < NREG + 2; i++) cycle();
        dump_check("t6_final_regs");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        check("sb_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
